// File: rtl/universal_shift_register.sv
// universal_shift_register: shift/rotate register with parallel load, manual step and counted automatic shifts
// Ports: clk/reset (async, active-high); load+parallelInput parallel load; serialInput fill bit;
//   mode shift mode; start+shiftCount counted run; shift single manual step;
//   parallelOutput contents; serialOutput last bit out; busy high during a run; done one-cycle completion pulse.
module universal_shift_register #(
  parameter int WORD_LENGTH = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [WORD_LENGTH-1:0] parallelInput,
  input  logic                   serialInput,
  input  logic [2:0]             mode,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] shiftCount,
  input  logic                   shift,
  output logic [WORD_LENGTH-1:0] parallelOutput,
  output logic                   serialOutput,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [COUNT_WIDTH-1:0] remain;
  logic [2:0] mode_q;
  logic busy_nxt, done_nxt;
  // returns {bit shifted out, new word}; reserved modes hold both
  function automatic logic [WORD_LENGTH:0] step(input logic [WORD_LENGTH-1:0] d, input logic [2:0] m,
                                                input logic sin, input logic sout);
    case (m)
      3'd0: step = {d[WORD_LENGTH-1], d[WORD_LENGTH-2:0], sin};
      3'd1: step = {d[0], sin, d[WORD_LENGTH-1:1]};
      3'd2: step = {d[0], d[WORD_LENGTH-1], d[WORD_LENGTH-1:1]};
      3'd3: step = {d[WORD_LENGTH-1], d[WORD_LENGTH-2:0], d[WORD_LENGTH-1]};
      3'd4: step = {d[0], d[0], d[WORD_LENGTH-1:1]};
      default: step = {sout, d};
    endcase
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  // count 0 or a reserved mode skips RUN and completes immediately
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (!load && start) ? ((shiftCount != '0 && mode < 3'd5) ? RUN : DONE) : IDLE;
      RUN:  state_nxt = (remain == COUNT_WIDTH'(1)) ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy_nxt = state_nxt == RUN;
    done_nxt = state_nxt == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      parallelOutput <= '0;
      serialOutput   <= 1'b0;
      remain         <= '0;
      mode_q         <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        parallelOutput <= parallelInput;
        serialOutput   <= 1'b0;
      end else if (start) begin
        mode_q <= mode;
        remain <= shiftCount;
      end else if (shift)
        {serialOutput, parallelOutput} <= step(parallelOutput, mode, serialInput, serialOutput);
    end else if (state == RUN) begin
      {serialOutput, parallelOutput} <= step(parallelOutput, mode_q, serialInput, serialOutput);
      remain <= remain - COUNT_WIDTH'(1);
    end
endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 8, giving the data width in bits (minimum 2).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 4, giving the width of the shift-count input.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-006 The block SHALL have port load, input, 1 bit, a parallel load request.
REQ-007 The block SHALL have port parallelInput, input, WORD_LENGTH bits, the load data.
REQ-008 The block SHALL have port serialInput, input, 1 bit, the fill bit for logical shifts.
REQ-009 The block SHALL have port mode, input, 3 bits, the shift mode.
REQ-010 The block SHALL have port start, input, 1 bit, which begins an automatic multi-step shift.
REQ-011 The block SHALL have port shiftCount, input, COUNT_WIDTH bits, the number of steps for start.
REQ-012 The block SHALL have port shift, input, 1 bit, a manual single-step request.
REQ-013 The block SHALL have port parallelOutput, output, WORD_LENGTH bits, the register contents.
REQ-014 The block SHALL have port serialOutput, output, 1 bit, the last bit shifted out.
REQ-015 The block SHALL have port busy, output, 1 bit, which is high while an automatic shift is running.
REQ-016 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-017 The block SHALL decode mode as follows:
- 000 SHL: serialInput into LSB, old MSB out.
- 001 SHR: serialInput into MSB, old LSB out.
- 010 ASR: MSB replicated, old LSB out.
- 011 ROL: old MSB into LSB and out.
- 100 ROR: old LSB into MSB and out.
- 101–111: reserved; no register change.
REQ-018 The block SHALL have FSM states IDLE, RUN and DONE; all outputs are registered.
REQ-019 In IDLE, priority SHALL be load > start > shift, with exactly one action per cycle.
REQ-020 A load in IDLE SHALL set parallelOutput to parallelInput and serialOutput to 0 at the next edge.
REQ-021 A shift in IDLE SHALL perform one step of the current mode at the next edge, with serialOutput updated; a reserved mode SHALL leave both unchanged.
REQ-022 A start in IDLE SHALL latch mode and shiftCount; the latched values, not the live inputs, govern the whole operation.
REQ-023 After start with latched count N ≥ 1 and a valid mode, the block SHALL:
- enter RUN with busy=1;
- perform one step per cycle, using the live serialInput for SHL/SHR fill;
- enter DONE after exactly N steps.
REQ-024 The start edge SHALL be edge 0; step k SHALL occur at edge k, and busy SHALL be high for exactly N cycles.
REQ-025 The block SHALL hold done=1 for exactly one cycle, the cycle after edge N, then return to IDLE with done=0.
REQ-026 A start with count 0 or a reserved mode SHALL go directly to DONE with no register change; done SHALL pulse in the cycle after edge 0 and busy SHALL stay 0.
REQ-027 In RUN and DONE, load, start and shift SHALL be ignored, with no queuing.
REQ-028 A start asserted in the DONE cycle SHALL be ignored; a start held high SHALL be accepted in the following IDLE cycle.
REQ-029 The remaining-step counter SHALL be COUNT_WIDTH bits, and the maximum count 2^COUNT_WIDTH−1 SHALL be supported without wrap.
REQ-030 Shift counts of WORD_LENGTH or more SHALL be legal: rotates wrap modulo WORD_LENGTH, SHL/SHR fill entirely with serialInput, and ASR fills entirely with the sign bit.

Reset
REQ-031 Reset assertion SHALL immediately, asynchronously, set parallelOutput=0, serialOutput=0, busy=0 and done=0, set the state to IDLE and clear the counter and latched mode.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-033 The first edge after reset deassertion SHALL accept load, start or shift normally.

Verification (WORD_LENGTH=8, COUNT_WIDTH=4)
REQ-034 Reset: assert reset with any state -> parallelOutput=0x00, serialOutput=0, busy=0, done=0 without waiting for a clock.
REQ-035 SHL: load 0xAA, start mode=000, count=1, serialInput=0 -> 0x54, serialOutput=1, busy high 1 cycle, done pulse the next cycle.
REQ-036 ASR: load 0x96, start mode=010, count=3 -> 0xF2, serialOutput=1, busy high 3 cycles, load pulses during RUN ignored.
REQ-037 Rotate and manual step:
- load 0x81, start mode=011, count=8 -> 0x81, busy high 8 cycles.
- then shift with mode=100 -> 0xC0, serialOutput=1.
REQ-038 Zero-step starts:
- start count=0 -> done pulses in the cycle after edge 0, busy stays 0, data unchanged.
- start mode=110 with count=5 -> the same behaviour.
REQ-039 Abort: load 0xFF, start SHR count=7 serialInput=0, assert reset after 4 steps -> 0x00, no done; then a load of 0x0F followed by a 1-step SHL with serialInput=1 -> 0x1F.
